// File: rtl/rsa_modexp_if.sv
// Register bus interface for rsa_modexp.
//   bus_write_en   : write strobe, one write per cycle
//   bus_read_en    : read strobe
//   bus_addr       : byte address (bits [1:0] ignored by the slave)
//   bus_write_data : write data
//   bus_read_data  : combinational read data from the slave
interface rsa_modexp_if;
   logic        bus_write_en;
   logic        bus_read_en;
   logic [7:0]  bus_addr;
   logic [31:0] bus_write_data;
   logic [31:0] bus_read_data;

   modport master (
      output bus_write_en, bus_read_en, bus_addr, bus_write_data,
      input  bus_read_data
   );

   modport slave (
      input  bus_write_en, bus_read_en, bus_addr, bus_write_data,
      output bus_read_data
   );
endinterface

// File: rtl/rsa_modexp.sv
// Modular exponentiation engine: RES = MSG^EXP mod MOD using MSB-first
// square-and-multiply with a bit-serial interleaved modular multiplier.
// Ports:
//   pclk   : clock, all state changes on rising edge
//   nreset : asynchronous active-low reset
//   bus    : register bus slave for control, status, exponent, modulus,
//            message and result registers
//   irq    : DONE & IRQ_EN, registered (only with RSA_MODEXP_IRQ_EN)
// Optional feature macro: RSA_MODEXP_IRQ_EN (irq port and CTRL.IRQ_EN bit).
module rsa_modexp #(
   parameter int unsigned KEY_W = 64,
   parameter int unsigned EXP_W = 24
) (
   input logic         pclk,
   input logic         nreset,
   rsa_modexp_if.slave bus
`ifdef RSA_MODEXP_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int unsigned NW       = KEY_W / 32;
   localparam int unsigned PW       = KEY_W + 2;
   localparam int unsigned CNT_W    = $clog2(KEY_W);
   localparam int unsigned IDX_W    = (EXP_W > 1) ? $clog2(EXP_W) : 1;
   localparam int unsigned MOD_BASE = 4;   // 0x10 >> 2
   localparam int unsigned MSG_BASE = 20;  // 0x50 >> 2
   localparam int unsigned RES_BASE = 36;  // 0x90 >> 2

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_SQR   = 3'd2;
   localparam logic [2:0] S_MUL   = 3'd3;
   localparam logic [2:0] S_NEXT  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]       state_q, state_d;
   logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [EXP_W-1:0] exp_q, exp_d;
   logic [KEY_W-1:0] mod_q, mod_d, msg_q, msg_d, res_q, res_d, acc_q, acc_d;
   logic [PW-1:0]    prod_q, prod_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             irq_en_q, irq_en_d;
`ifdef RSA_MODEXP_IRQ_EN
   logic             irq_q, irq_d;
   assign irq = irq_q;
`endif

   logic [5:0]       word_c;
   logic             unused_addr_c;
   logic             wr_ctrl_c, start_c, abort_c;
   assign word_c        = bus.bus_addr[7:2];
   assign unused_addr_c = ^bus.bus_addr[1:0];
   assign wr_ctrl_c     = bus.bus_write_en && (word_c == 6'd0);
   assign start_c       = wr_ctrl_c && bus.bus_write_data[0];
   assign abort_c       = wr_ctrl_c && bus.bus_write_data[1];

   // One step of the interleaved multiply: 2*prod + (bit ? a : 0), reduced twice.
   logic [KEY_W-1:0] a_c;
   logic             mbit_c;
   logic [PW-1:0]    mod_ext_c, sum_c, red1_c, red_c;
   always_comb begin
      a_c       = (state_q == S_MUL) ? msg_q : acc_q;
      mbit_c    = acc_q[cnt_q];
      mod_ext_c = {2'b00, mod_q};
      sum_c     = (prod_q << 1) + (mbit_c ? {2'b00, a_c} : PW'(0));
      red1_c    = (sum_c >= mod_ext_c) ? sum_c - mod_ext_c : sum_c;
      red_c     = (red1_c >= mod_ext_c) ? red1_c - mod_ext_c : red1_c;
   end

   // Register writes and FSM next state.
   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      done_d   = done_q;
      err_d    = err_q;
      exp_d    = exp_q;
      mod_d    = mod_q;
      msg_d    = msg_q;
      res_d    = res_q;
      acc_d    = acc_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      irq_en_d = irq_en_q;

      if (bus.bus_write_en && !busy_q) begin
         if (word_c == 6'd2) exp_d = bus.bus_write_data[EXP_W-1:0];
         for (int k = 0; k < NW; k++) begin
            if (word_c == 6'(MOD_BASE + k)) mod_d[32*k +: 32] = bus.bus_write_data;
            if (word_c == 6'(MSG_BASE + k)) msg_d[32*k +: 32] = bus.bus_write_data;
         end
      end
`ifdef RSA_MODEXP_IRQ_EN
      if (wr_ctrl_c) irq_en_d = bus.bus_write_data[2];
`else
      irq_en_d = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (start_c && !abort_c) begin
               state_d = S_CHECK;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         S_CHECK: begin
            acc_d  = KEY_W'(1);
            prod_d = '0;
            cnt_d  = CNT_W'(KEY_W - 1);
            idx_d  = IDX_W'(EXP_W - 1);
            if ((mod_q < KEY_W'(2)) || (msg_q >= mod_q)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               state_d = S_SQR;
            end
         end
         S_SQR, S_MUL: begin
            prod_d = red_c;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               acc_d  = red_c[KEY_W-1:0];
               prod_d = '0;
               cnt_d  = CNT_W'(KEY_W - 1);
               state_d = (state_q == S_SQR && exp_q[idx_q]) ? S_MUL : S_NEXT;
            end
         end
         S_NEXT: begin
            if (idx_q == '0) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q - IDX_W'(1);
               state_d = S_SQR;
            end
         end
         S_DONE: begin
            if (!err_q) res_d = acc_q;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort cancels a running job without touching RES.
      if (abort_c && busy_q) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         res_d   = res_q;
      end
   end

`ifdef RSA_MODEXP_IRQ_EN
   assign irq_d = done_d & irq_en_d;
`endif

   always_ff @(posedge pclk or negedge nreset) begin
      if (!nreset) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         exp_q    <= '0;
         mod_q    <= '0;
         msg_q    <= '0;
         res_q    <= '0;
         acc_q    <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         irq_en_q <= 1'b0;
`ifdef RSA_MODEXP_IRQ_EN
         irq_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         exp_q    <= exp_d;
         mod_q    <= mod_d;
         msg_q    <= msg_d;
         res_q    <= res_d;
         acc_q    <= acc_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         irq_en_q <= irq_en_d;
`ifdef RSA_MODEXP_IRQ_EN
         irq_q    <= irq_d;
`endif
      end
   end

   // Combinational read mux; unmapped and write-only bits read 0.
   always_comb begin
      bus.bus_read_data = '0;
      if (bus.bus_read_en) begin
         if (word_c == 6'd0) bus.bus_read_data = {29'd0, irq_en_q, 2'b00};
         if (word_c == 6'd1) bus.bus_read_data = {29'd0, err_q, done_q, busy_q};
         if (word_c == 6'd2) bus.bus_read_data = 32'(exp_q);
         for (int k = 0; k < NW; k++) begin
            if (word_c == 6'(MOD_BASE + k)) bus.bus_read_data = mod_q[32*k +: 32];
            if (word_c == 6'(MSG_BASE + k)) bus.bus_read_data = msg_q[32*k +: 32];
            if (word_c == 6'(RES_BASE + k)) bus.bus_read_data = res_q[32*k +: 32];
         end
      end
   end

endmodule

// File: tb/tb_rsa_modexp.sv
// Directed testbench for rsa_modexp (KEY_W=64, EXP_W=24).
module tb_rsa_modexp;
   logic pclk   = 1'b0;
   logic nreset = 1'b1;
`ifdef RSA_MODEXP_IRQ_EN
   logic irq;
`endif
   int n_assert = 0;
   int n_fail   = 0;

   rsa_modexp_if bif ();

   rsa_modexp #(.KEY_W(64), .EXP_W(24)) dut (
      .pclk   (pclk),
      .nreset (nreset),
      .bus    (bif)
`ifdef RSA_MODEXP_IRQ_EN
      ,
      .irq    (irq)
`endif
   );

   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      @(negedge pclk);
      bif.bus_write_en   = 1'b1;
      bif.bus_addr       = a;
      bif.bus_write_data = d;
      @(posedge pclk);
      #1;
      bif.bus_write_en = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      bif.bus_read_en = 1'b1;
      bif.bus_addr    = a;
      #1;
      d = bif.bus_read_data;
      bif.bus_read_en = 1'b0;
   endtask

   task automatic wr64(input logic [7:0] base, input logic [63:0] v);
      wr(base, v[31:0]);
      wr(base + 8'd4, v[63:32]);
   endtask

   task automatic rd64(input logic [7:0] base, output logic [63:0] v);
      logic [31:0] lo, hi;
      rd(base, lo);
      rd(base + 8'd4, hi);
      v = {hi, lo};
   endtask

   // Counts rising edges until STATUS.DONE is seen; -1 if the bound expires.
   task automatic wait_done(output int cyc, output logic busy_ok);
      logic [31:0] s;
      cyc     = -1;
      busy_ok = 1'b1;
      for (int i = 1; i <= 5000; i++) begin
         @(posedge pclk);
         #1;
         rd(8'h04, s);
         if (s[1]) begin
            cyc = i;
            break;
         end
         if (!s[0]) busy_ok = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] d;
      logic [63:0] v;
      int          cyc;
      logic        bok;

      bif.bus_write_en   = 1'b0;
      bif.bus_read_en    = 1'b0;
      bif.bus_addr       = '0;
      bif.bus_write_data = '0;

      // Asynchronous reset before any clock edge.
      #2 nreset = 1'b0;
      #1;
      rd(8'h04, d);  check("rst_status", 64'(d), 64'd0);
      rd(8'h00, d);  check("rst_ctrl", 64'(d), 64'd0);
      rd(8'h08, d);  check("rst_exp", 64'(d), 64'd0);
      rd64(8'h10, v); check("rst_mod", v, 64'd0);
      rd64(8'h90, v); check("rst_res", v, 64'd0);
      repeat (2) @(posedge pclk);
      @(negedge pclk) nreset = 1'b1;

      // 65^17 mod 3233 = 2790; 2 + 24*65 + 2*64 = 1690 cycles.
      wr64(8'h10, 64'd3233);
      wr64(8'h50, 64'd65);
      wr(8'h08, 32'd17);
      rd(8'h08, d);  check("exp_rb", 64'(d), 64'd17);
      rd64(8'h10, v); check("mod_rb", v, 64'd3233);
      wr(8'h00, 32'd1);
      rd(8'h04, d);  check("busy_after_start", 64'(d), 64'd1);
      wait_done(cyc, bok);
      check("enc_cycles", 64'(cyc), 64'd1690);
      check("enc_busy_held", 64'(bok), 64'd1);
      rd64(8'h90, v); check("enc_res", v, 64'd2790);
      rd(8'h04, d);  check("enc_status", 64'(d), 64'd2);

      // 2790^2753 mod 3233 = 65; popcount(2753)=5 -> 2 + 1560 + 320 = 1882.
      wr(8'h08, 32'd2753);
      wr64(8'h50, 64'd2790);
      wr(8'h00, 32'd1);
      wait_done(cyc, bok);
      check("dec_cycles", 64'(cyc), 64'd1882);
      rd64(8'h90, v); check("dec_res", v, 64'd65);
      rd(8'h04, d);  check("dec_status", 64'(d), 64'd2);

      // MSG >= MOD: error, DONE two edges after START, RES kept.
      wr64(8'h50, 64'd3233);
      wr(8'h00, 32'd1);
      wait_done(cyc, bok);
      check("err_cycles", 64'(cyc), 64'd2);
      rd(8'h04, d);  check("err_status", 64'(d), 64'd6);
      rd64(8'h90, v); check("err_res_kept", v, 64'd65);

      // A modulus of 1 is also an error.
      wr64(8'h10, 64'd1);
      wr64(8'h50, 64'd0);
      wr(8'h00, 32'd1);
      wait_done(cyc, bok);
      rd(8'h04, d);  check("mod1_status", 64'(d), 64'd6);
      rd64(8'h90, v); check("mod1_res_kept", v, 64'd65);

      // EXP=0 -> RES=1; EXP write and START during BUSY are ignored.
      wr64(8'h10, 64'd3233);
      wr64(8'h50, 64'd5);
      wr(8'h08, 32'd0);
      wr(8'h00, 32'd1);
      wr(8'h08, 32'd17);
      wr(8'h00, 32'd1);
      wait_done(cyc, bok);
      // Two write cycles elapsed before counting: 2 + 24*65 - 2.
      check("exp0_cycles", 64'(cyc), 64'd1560);
      rd64(8'h90, v); check("exp0_res", v, 64'd1);
      rd(8'h08, d);  check("exp0_exp_kept", 64'(d), 64'd0);
      rd(8'h04, d);  check("exp0_status", 64'(d), 64'd2);

      // ABORT around cycle 500 of a run.
      wr(8'h08, 32'd17);
      wr64(8'h50, 64'd65);
      wr(8'h00, 32'd1);
      repeat (498) @(posedge pclk);
      wr(8'h00, 32'd2);
      rd(8'h04, d);  check("abort_status", 64'(d), 64'd0);
      rd64(8'h90, v); check("abort_res_kept", v, 64'd1);
      repeat (5) @(posedge pclk);
      #1;
      rd(8'h04, d);  check("abort_idle", 64'(d), 64'd0);

      // ABORT in IDLE is a no-op; ABORT+START together does not start.
      wr(8'h00, 32'd3);
      repeat (3) @(posedge pclk);
      #1;
      rd(8'h04, d);  check("abort_start_idle", 64'(d), 64'd0);

      // Unmapped accesses and reads with bus_read_en low return 0.
      wr(8'hF0, 32'hDEAD_BEEF);
      rd(8'hF0, d);  check("unmapped_rd", 64'(d), 64'd0);
      bif.bus_addr = 8'h10;
      #1;
      check("rd_en_low", 64'(bif.bus_read_data), 64'd0);

      // Reset mid-run clears everything; a clean rerun still works.
      wr(8'h00, 32'd1);
      repeat (300) @(posedge pclk);
      @(negedge pclk) nreset = 1'b0;
      #2;
      rd(8'h04, d);  check("midrst_status", 64'(d), 64'd0);
      rd(8'h08, d);  check("midrst_exp", 64'(d), 64'd0);
      rd64(8'h10, v); check("midrst_mod", v, 64'd0);
      rd64(8'h50, v); check("midrst_msg", v, 64'd0);
      rd64(8'h90, v); check("midrst_res", v, 64'd0);
      @(negedge pclk) nreset = 1'b1;
      wr64(8'h10, 64'd3233);
      wr64(8'h50, 64'd65);
      wr(8'h08, 32'd17);
      wr(8'h00, 32'd1);
      wait_done(cyc, bok);
      check("rerun_cycles", 64'(cyc), 64'd1690);
      rd64(8'h90, v); check("rerun_res", v, 64'd2790);

`ifdef RSA_MODEXP_IRQ_EN
      wr(8'h00, 32'd4);
      rd(8'h00, d);  check("irq_en_rb", 64'(d), 64'd4);
      wr64(8'h50, 64'd3233);
      wr(8'h00, 32'd5);
      check("irq_low_busy", 64'(irq), 64'd0);
      wait_done(cyc, bok);
      check("irq_with_done", 64'(irq), 64'd1);
      wr(8'h00, 32'd5);
      check("irq_clr_start", 64'(irq), 64'd0);
      wait_done(cyc, bok);
      wr(8'h00, 32'd1);
      wait_done(cyc, bok);
      check("irq_dis_done", 64'(cyc), 64'd2);
      check("irq_disabled", 64'(irq), 64'd0);
`else
      wr(8'h00, 32'd4);
      rd(8'h00, d);  check("irq_en_absent", 64'(d), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/rsa_modexp.md
RSA_MODEXP -- requirements
Module: rsa_modexp

Interface
REQ-001 SHALL have parameter KEY_W, default 64: modulus/message/result width in bits; multiple of 32; range 64..512.
REQ-002 SHALL have parameter EXP_W, default 24: exponent width in bits; range 1..32.
REQ-003 SHALL have port pclk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port nreset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port bus_write_en, input, 1: write strobe, one write per cycle when high.
REQ-006 SHALL have port bus_read_en, input, 1: read strobe.
REQ-007 SHALL have port bus_addr, input, 8: byte address; bits [1:0] ignored.
REQ-008 SHALL have port bus_write_data, input, 32: write data.
REQ-009 SHALL have port bus_read_data, output, 32: read data.
REQ-010 SHALL have port irq, output, 1, present only when RSA_MODEXP_IRQ_EN is defined: completion interrupt.

Function
REQ-011 SHALL decode these addresses:
- 0x00 CTRL (W): bit0 START, bit1 ABORT, bit2 IRQ_EN (R/W).
- 0x04 STATUS (R): bit0 BUSY, bit1 DONE, bit2 ERROR.
- 0x08 EXP (R/W): bits [EXP_W-1:0].
- 0x10+4k MOD[k], 0x50+4k MSG[k], 0x90+4k RES[k] (RES read-only); k=0..KEY_W/32-1; word 0 = least significant.
REQ-012 SHALL drive bus_read_data combinationally with the addressed register when bus_read_en=1; unmapped addresses, write-only bits and bus_read_en=0 SHALL return 0.
REQ-013 SHALL ignore writes to EXP, MOD and MSG while BUSY=1; writes at unmapped addresses SHALL have no effect.
REQ-014 SHALL compute RES = MSG^EXP mod MOD by left-to-right square-and-multiply over all EXP_W exponent bits, MSB first, with no leading-zero skip.
REQ-015 SHALL perform each modular multiply bit-serially: KEY_W cycles, one multiplier bit per cycle, acc=2*acc+(bit?a:0), reduced into [0,MOD) by at most two conditional subtractions of MOD in the same cycle; intermediates SHALL be KEY_W+2 bits wide.
REQ-016 SHALL implement the FSM IDLE -> CHECK -> SQR -> (MUL if the exponent bit is 1) -> NEXT -> SQR ... -> DONE -> IDLE.
REQ-017 SHALL leave IDLE on a START write in IDLE, clear DONE and ERROR, and set BUSY in the following cycle.
REQ-018 In CHECK, SHALL set acc=1 and proceed; if MOD<2 or MSG>=MOD, SHALL instead set ERROR and go to DONE, leaving RES unchanged.
REQ-019 SHALL spend exactly 1 cycle in NEXT and decrement the bit index there; after bit 0 it SHALL go to DONE.
REQ-020 In DONE, SHALL load RES with acc, clear BUSY, set DONE, and return to IDLE in 1 cycle.
REQ-021 SHALL set DONE exactly 2+EXP_W*(KEY_W+1)+popcount(EXP)*KEY_W cycles after the START write edge on the success path, and 2 cycles after it on the error path.
REQ-022 SHALL ignore START while BUSY=1.
REQ-023 SHALL return to IDLE on ABORT while BUSY=1, with BUSY=0 and DONE=0 in the next cycle and RES unchanged; ABORT in IDLE SHALL have no effect.
REQ-024 SHALL give ABORT priority over START when both bits are set in one write.
REQ-025 SHALL produce RES=1 for EXP=0 when MOD>=2.
REQ-026 SHALL keep DONE and ERROR sticky until the next accepted START.

Reset
REQ-027 SHALL, while nreset=0 and regardless of the clock, put the FSM in IDLE and clear BUSY, DONE, ERROR, IRQ_EN, EXP, MOD, MSG, RES and acc to 0; irq SHALL be 0.
REQ-028 SHALL discard any operation in progress on reset with no partial RES update; operation SHALL resume on the first clock edge after nreset=1.

Configuration
REQ-029 With RSA_MODEXP_IRQ_EN defined, SHALL provide port irq = DONE & IRQ_EN, registered, and CTRL bit2 SHALL be R/W.
REQ-030 Without RSA_MODEXP_IRQ_EN, SHALL omit port irq, and CTRL bit2 SHALL be write-ignored and read 0.

Verification
REQ-031 SHALL cover: KEY_W=64, EXP_W=24, MOD=3233, EXP=17, MSG=65, START -> RES=2790, DONE after 2+24*65+2*64=1690 cycles, BUSY high throughout.
REQ-032 SHALL cover: MOD=3233, EXP=2753, MSG=2790 -> RES=65, ERROR=0.
REQ-033 SHALL cover: MOD=3233, MSG=3233, START -> ERROR=1, DONE at cycle 2, RES keeps its prior value; a second run with MOD=1 -> ERROR=1.
REQ-034 SHALL cover: EXP=0, MOD=3233, MSG=5 -> RES=1; a START and an EXP write issued while BUSY -> both ignored and the result unaffected.
REQ-035 SHALL cover: ABORT at cycle 500 of a run -> BUSY=0 and DONE=0 next cycle, RES unchanged; nreset pulsed mid-run -> all registers 0 and a clean rerun gives the correct RES.
REQ-036 SHALL cover, with RSA_MODEXP_IRQ_EN: IRQ_EN=1 -> irq rises with DONE and clears on the next START; IRQ_EN=0 -> irq stays 0.
